s2p_deserializer: RTL and testbench

- Parametrised serial-to-parallel receiver; successor to the fixed 8-bit shift register.
- Samples an externally driven serial clock and data pair, synchronously to the system clock, under a frame-enable window.
- Assembles WIDTH-bit words, MSB- or LSB-first, and presents each through a one-entry valid/ready output buffer with overrun and short-frame reporting.
- Sits between the inter-board serial link pins and the game-state logic.

---
 rtl/s2p_pkg.sv | 11 +
 rtl/sync_edge_det.sv | 24 ++
 rtl/s2p_deserializer.sv | 91 +++++++++
 tb/tb_s2p_deserializer.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/s2p_pkg.sv
// s2p_pkg: shared state encoding, limits and counter-width helper for s2p_deserializer.
package s2p_pkg;
  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_PARITY} state_t;
  localparam int SYNC_MIN = 2;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/sync_edge_det.sv
// sync_edge_det: STAGES-deep synchroniser for W async inputs; din[0] also gets a rising-edge pulse.
module sync_edge_det #(
  parameter int W = 2,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] din,
  output logic [W-2:0] sync,
  output logic         rise
);
  logic [STAGES-1:0][W-1:0] pipe;
  logic prev;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      pipe <= '0;
      prev <= 1'b0;
    end else begin
      pipe <= {pipe[STAGES-2:0], din};
      prev <= pipe[STAGES-1][0];
    end
  assign sync = pipe[STAGES-1][W-1:1];
  assign rise = pipe[STAGES-1][0] & ~prev;
endmodule

// File: rtl/s2p_deserializer.sv
// s2p_deserializer: framed serial-to-parallel receiver with one-entry valid/ready output buffer.
// Optional even-parity bit per word when S2P_DESER_PARITY_EN is defined.
module s2p_deserializer
  import s2p_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter int SYNC_STAGES = SYNC_MIN
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sclk,
  input  logic             sdata,
  input  logic             frame,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  input  logic             data_ready,
  output logic             overrun,
  input  logic             clear_ovr,
  output logic             short_frame,
`ifdef S2P_DESER_PARITY_EN
  output logic             parity_err,
`endif
  output logic             busy
);
  localparam int CW = clog2(WIDTH + 1);
  state_t state, state_nxt;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] shreg, shifted, word;
  logic frame_s, sdata_s, rise, take, shift_en, last, word_done, load_ok;
  sync_edge_det #(.W(3), .STAGES(SYNC_STAGES)) u_sync (
    .clk(clk),
    .reset(reset),
    .din({sdata, frame, sclk}),
    .sync({sdata_s, frame_s}),
    .rise(rise)
  );
  assign take     = rise && frame_s && state != S_IDLE;
  assign shift_en = take && state == S_SHIFT;
  assign last     = cnt == CW'(WIDTH - 1);
  assign shifted  = MSB_FIRST ? {shreg[WIDTH-2:0], sdata_s} : {sdata_s, shreg[WIDTH-1:1]};
  assign load_ok  = !data_valid || data_ready;
  assign busy     = state == S_SHIFT;
`ifdef S2P_DESER_PARITY_EN
  assign word_done = take && state == S_PARITY;
  assign word      = shreg;
`else
  assign word_done = shift_en && last;
  assign word      = shifted;
`endif
  always_comb begin
    state_nxt = state;
    if (!frame_s) state_nxt = S_IDLE;
    else if (state == S_IDLE) state_nxt = S_SHIFT;
`ifdef S2P_DESER_PARITY_EN
    else if (shift_en && last) state_nxt = S_PARITY;
    else if (word_done) state_nxt = S_SHIFT;
`endif
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= S_IDLE;
    else state <= state_nxt;
  // With parity the counter parks at WIDTH in PARITY, so a frame fall there reads as short.
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      cnt         <= '0;
      shreg       <= '0;
      short_frame <= 1'b0;
    end else begin
      short_frame <= state != S_IDLE && !frame_s && cnt != '0;
      cnt         <= (!frame_s || state == S_IDLE || word_done) ? '0 : shift_en ? cnt + 1'b1 : cnt;
      if (shift_en) shreg <= shifted;
    end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      data_out   <= '0;
      data_valid <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (word_done && load_ok) begin
        data_out   <= word;
        data_valid <= 1'b1;
      end else if (data_ready) data_valid <= 1'b0;
      overrun <= (word_done && !load_ok) ? 1'b1 : clear_ovr ? 1'b0 : overrun;
    end
`ifdef S2P_DESER_PARITY_EN
  always_ff @(posedge clk or posedge reset)
    if (reset) parity_err <= 1'b0;
    else parity_err <= word_done && ^{shreg, sdata_s};
`endif
endmodule

// File: tb/tb_s2p_deserializer.sv
// tb_s2p_deserializer: directed scoreboard bench for an MSB-first and an LSB-first receiver on one link.
module tb_s2p_deserializer;
  logic clk = 0, reset = 1, sclk = 0, sdata = 0, frame = 0;
  logic data_ready = 0, clear_ovr = 0, ready_l = 1;
  logic [7:0] data_out, data_out_l;
  logic data_valid, valid_l, overrun, ovr_l, short_frame, short_l, busy, busy_l;
`ifdef S2P_DESER_PARITY_EN
  logic parity_err, perr_l;
`endif
  int errors = 0, checks = 0, shorts = 0, shorts_l = 0;
  logic [7:0] exp_q[$], exp_lq[$];

  always #5 clk = ~clk;

  s2p_deserializer #(.WIDTH(8), .MSB_FIRST(1'b1), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .sclk(sclk), .sdata(sdata), .frame(frame),
    .data_out(data_out), .data_valid(data_valid), .data_ready(data_ready),
    .overrun(overrun), .clear_ovr(clear_ovr), .short_frame(short_frame),
`ifdef S2P_DESER_PARITY_EN
    .parity_err(parity_err),
`endif
    .busy(busy)
  );

  s2p_deserializer #(.WIDTH(8), .MSB_FIRST(1'b0), .SYNC_STAGES(2)) dut_l (
    .clk(clk), .reset(reset), .sclk(sclk), .sdata(sdata), .frame(frame),
    .data_out(data_out_l), .data_valid(valid_l), .data_ready(ready_l),
    .overrun(ovr_l), .clear_ovr(clear_ovr), .short_frame(short_l),
`ifdef S2P_DESER_PARITY_EN
    .parity_err(perr_l),
`endif
    .busy(busy_l)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    #1;
    if (!reset) begin
      if (data_valid && data_ready) begin
        if (exp_q.size() == 0) check("msb_unexpected_word", {24'd0, data_out}, 32'hdead);
        else check("msb_word", {24'd0, data_out}, {24'd0, exp_q.pop_front()});
      end
      if (valid_l) begin
        if (exp_lq.size() == 0) check("lsb_unexpected_word", {24'd0, data_out_l}, 32'hdead);
        else check("lsb_word", {24'd0, data_out_l}, {24'd0, exp_lq.pop_front()});
      end
      if (short_frame) shorts++;
      if (short_l) shorts_l++;
    end
  end

  task automatic send_bit(input logic b);
    repeat (3) @(negedge clk);
    sclk = 0;
    sdata = b;
    repeat (3) @(negedge clk);
    sclk = 1;
  endtask

  task automatic send_word(input logic [7:0] w, input logic p);
    for (int i = 7; i >= 0; i--) send_bit(w[i]);
`ifdef S2P_DESER_PARITY_EN
    send_bit(p);
`endif
  endtask

  task automatic open_frame();
    @(negedge clk);
    frame = 1;
    repeat (5) @(negedge clk);
  endtask

  task automatic close_frame();
    repeat (4) @(negedge clk);
    frame = 0;
    repeat (8) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_data_out", {24'd0, data_out}, 0);
    check("rst_valid", {31'd0, data_valid}, 0);
    check("rst_overrun", {31'd0, overrun}, 0);
    check("rst_short", {31'd0, short_frame}, 0);
    check("rst_busy", {31'd0, busy}, 0);
    reset = 0;
    // basic word with exact latency
    open_frame();
    check("busy_in_frame", {31'd0, busy}, 1);
    exp_lq.push_back(8'hA5);
    send_word(8'hA5, 1'b0);
    repeat (2) @(negedge clk);
    check("lat_early_valid", {31'd0, data_valid}, 0);
    @(negedge clk);
    check("lat_valid", {31'd0, data_valid}, 1);
    check("lat_data", {24'd0, data_out}, 32'hA5);
    exp_q.push_back(8'hA5);
    @(negedge clk);
    data_ready = 1;
    @(negedge clk);
    data_ready = 0;
    check("valid_after_accept", {31'd0, data_valid}, 0);
    // bit order and back-to-back with ready held
    data_ready = 1;
    exp_q.push_back(8'h80);
    exp_lq.push_back(8'h01);
    send_word(8'h80, 1'b1);
    exp_q.push_back(8'h3C);
    exp_lq.push_back(8'h3C);
    exp_q.push_back(8'hC3);
    exp_lq.push_back(8'hC3);
    send_word(8'h3C, 1'b0);
    send_word(8'hC3, 1'b0);
    repeat (4) @(negedge clk);
    check("b2b_overrun", {31'd0, overrun}, 0);
    data_ready = 0;
    close_frame();
    // overrun
    open_frame();
    exp_lq.push_back(8'h88);
    exp_lq.push_back(8'h44);
    send_word(8'h11, 1'b0);
    send_word(8'h22, 1'b0);
    repeat (4) @(negedge clk);
    check("ovr_data_kept", {24'd0, data_out}, 32'h11);
    check("ovr_valid", {31'd0, data_valid}, 1);
    check("ovr_set", {31'd0, overrun}, 1);
    check("ovr_lsb_clear", {31'd0, ovr_l}, 0);
    clear_ovr = 1;
    @(negedge clk);
    clear_ovr = 0;
    check("ovr_cleared", {31'd0, overrun}, 0);
    exp_q.push_back(8'h11);
    data_ready = 1;
    @(negedge clk);
    data_ready = 0;
    close_frame();
    // short frame after 5 bits
    shorts = 0;
    shorts_l = 0;
    open_frame();
    send_bit(1); send_bit(0); send_bit(1); send_bit(1); send_bit(0);
    close_frame();
    check("short_pulses", shorts, 1);
    check("short_pulses_lsb", shorts_l, 1);
    check("short_no_valid", {31'd0, data_valid}, 0);
    check("short_idle", {31'd0, busy}, 0);
    // full word after short frame, then reset mid-word
    open_frame();
    exp_lq.push_back(8'h0F);
    send_word(8'hF0, 1'b0);
    repeat (4) @(negedge clk);
    check("after_short_data", {24'd0, data_out}, 32'hF0);
    check("after_short_valid", {31'd0, data_valid}, 1);
    send_bit(1); send_bit(1); send_bit(0);
    @(negedge clk);
    reset = 1;
    #1;
    check("arst_data_out", {24'd0, data_out}, 0);
    check("arst_valid", {31'd0, data_valid}, 0);
    check("arst_busy", {31'd0, busy}, 0);
    frame = 0;
    repeat (3) @(negedge clk);
    reset = 0;
    repeat (3) @(negedge clk);
`ifdef S2P_DESER_PARITY_EN
    open_frame();
    data_ready = 1;
    exp_q.push_back(8'h07);
    exp_lq.push_back(8'hE0);
    send_word(8'h07, 1'b0);
    repeat (2) @(negedge clk);
    check("perr_early", {31'd0, parity_err}, 0);
    @(negedge clk);
    check("perr_bad_parity", {31'd0, parity_err}, 1);
    exp_q.push_back(8'h07);
    exp_lq.push_back(8'hE0);
    send_word(8'h07, 1'b1);
    repeat (3) @(negedge clk);
    check("perr_good_parity", {31'd0, parity_err}, 0);
    check("perr_good_valid", {31'd0, data_valid}, 1);
    data_ready = 0;
    close_frame();
`endif
    repeat (10) @(negedge clk);
    check("msb_queue_drained", exp_q.size(), 0);
    check("lsb_queue_drained", exp_lq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
